// File: rtl/dpu_host_pkg.sv
// Shared types and core io_opcode table for the DPU host sequencer.
package dpu_host_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_CFG  = 3'd1,
        OP_DATA = 3'd2,
        OP_PROG = 3'd3,
        OP_EXEC = 3'd4,
        OP_READ = 3'd5
    } cmd_op_e;

    localparam logic [3:0] IO_NOP  = 4'h0;
    localparam logic [3:0] IO_CFG  = 4'h1;
    localparam logic [3:0] IO_DATA = 4'h2;
    localparam logic [3:0] IO_PROG = 4'h3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DRAIN
    } state_e;

    function automatic logic [3:0] op_io_opcode(input logic [2:0] op);
        case (op)
            OP_CFG:  return IO_CFG;
            OP_DATA: return IO_DATA;
            OP_PROG: return IO_PROG;
            default: return IO_NOP;
        endcase
    endfunction

endpackage

// File: rtl/dpu_host_cmd_fifo.sv
// Synchronous command FIFO (DEPTH power of 2); extra pointer bit separates full from empty.
module dpu_host_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/dpu_host_seq.sv
// Host-side sequencer driving N_CORES DPU cores from a queued command stream.
// Optional execution timeout: define DPU_HOST_TIMEOUT_EN.
module dpu_host_seq
    import dpu_host_pkg::*;
#(
    parameter int N_CORES    = 4,
    parameter int DATA_W     = 32,
    parameter int OPC_W      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TMO_W      = 20,
    localparam int CORE_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [N_CORES-1:0]        cmd_mask,
    input  logic [DATA_W-1:0]         cmd_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_data,
    output logic [CORE_W-1:0]         res_core,
    output logic                      status_err,
    output logic [N_CORES*DATA_W-1:0] core_in,
    output logic [N_CORES*OPC_W-1:0]  core_io_opcode,
    output logic [N_CORES-1:0]        core_reset_exec,
    output logic [N_CORES-1:0]        core_enable_exec,
    input  logic [N_CORES-1:0]        core_done_exec,
    input  logic [N_CORES*DATA_W-1:0] core_out
);

    localparam int CMD_W = 3 + N_CORES + DATA_W;

    state_e              r_state, w_next;
    logic [N_CORES-1:0]  r_mask, r_done_seen, r_remaining;
    logic [DATA_W-1:0]   r_data, r_res_data;
    logic [OPC_W-1:0]    r_ld_opc;
    logic [CORE_W-1:0]   r_res_core;

    logic                w_fifo_full, w_fifo_empty, w_pop;
    logic [CMD_W-1:0]    w_head;
    logic [2:0]          w_head_op;
    logic [N_CORES-1:0]  w_head_mask;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_done_all, w_found;
    logic [N_CORES-1:0]  w_pick_src, w_pick_bit;
    logic [CORE_W-1:0]   w_pick_idx;
    logic [DATA_W-1:0]   w_pick_data;

`ifdef DPU_HOST_TIMEOUT_EN
    logic [TMO_W-1:0]    r_tmo;
    logic                r_err;
    logic                w_tmo_last;
    assign w_tmo_last = (r_tmo == TMO_W'(1));
    assign status_err = r_err;
`else
    logic [TMO_W-1:0]    w_tmo_unused;
    assign w_tmo_unused = '0;
    assign status_err   = 1'b0;
`endif

    dpu_host_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_wdata ({cmd_op, cmd_mask, cmd_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign cmd_ready = !w_fifo_full;
    assign {w_head_op, w_head_mask, w_head_data} = w_head;

    // Lowest-index selector: picks the first core of a fresh READ in IDLE, the next one in DRAIN.
    always_comb begin
        w_pick_src  = (r_state == DRAIN) ? r_remaining : w_head_mask;
        w_pick_idx  = '0;
        w_pick_bit  = '0;
        w_pick_data = '0;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (w_pick_src[i] && !w_found) begin
                w_found     = 1'b1;
                w_pick_idx  = CORE_W'(i);
                w_pick_bit[i] = 1'b1;
                w_pick_data = core_out[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_done_all = ((r_done_seen | core_done_exec) & r_mask) == r_mask;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head_mask != '0) begin
                        case (w_head_op)
                            OP_CFG, OP_DATA, OP_PROG: w_next = LOAD;
                            OP_EXEC:                  w_next = START;
                            OP_READ:                  w_next = DRAIN;
                            default:                  w_next = IDLE;
                        endcase
                    end
                end
            end
            LOAD:  w_next = IDLE;
            START: w_next = RUN;
            RUN: begin
                if (w_done_all) w_next = IDLE;
`ifdef DPU_HOST_TIMEOUT_EN
                else if (w_tmo_last) w_next = IDLE;
`endif
            end
            DRAIN: if (res_ready && r_remaining == '0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        core_in        = '0;
        core_io_opcode = {N_CORES{OPC_W'(IO_NOP)}};
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (r_state == LOAD && r_mask[i]) begin
                core_in[i*DATA_W +: DATA_W]      = r_data;
                core_io_opcode[i*OPC_W +: OPC_W] = r_ld_opc;
            end
        end
    end

    assign core_reset_exec  = (r_state == START) ? r_mask : '0;
    assign core_enable_exec = (r_state == RUN)   ? r_mask : '0;
    assign res_valid        = (r_state == DRAIN);
    assign res_data         = r_res_data;
    assign res_core         = r_res_core;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_data      <= '0;
            r_ld_opc    <= '0;
            r_done_seen <= '0;
            r_remaining <= '0;
            r_res_data  <= '0;
            r_res_core  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_pop) begin
                    r_mask      <= w_head_mask;
                    r_data      <= w_head_data;
                    r_ld_opc    <= OPC_W'(op_io_opcode(w_head_op));
                    r_res_data  <= w_pick_data;
                    r_res_core  <= w_pick_idx;
                    r_remaining <= w_pick_src & ~w_pick_bit;
                end
                START: r_done_seen <= '0;
                RUN:   r_done_seen <= r_done_seen | (core_done_exec & r_mask);
                DRAIN: if (res_ready && r_remaining != '0) begin
                    r_res_data  <= w_pick_data;
                    r_res_core  <= w_pick_idx;
                    r_remaining <= w_pick_src & ~w_pick_bit;
                end
                default: ;
            endcase
        end
    end

`ifdef DPU_HOST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else if (r_state == START) begin
            r_tmo <= '1;
        end else if (r_state == RUN) begin
            r_tmo <= r_tmo - TMO_W'(1);
            if (!w_done_all && w_tmo_last) r_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dpu_host_seq.sv
// Directed self-checking bench for dpu_host_seq; timeout scenario runs when DPU_HOST_TIMEOUT_EN is defined.
module tb_dpu_host_seq;
    import dpu_host_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [3:0]   cmd_mask = '0;
    logic [31:0]  cmd_data = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [31:0]  res_data;
    logic [1:0]   res_core;
    logic         status_err;
    logic [127:0] core_in;
    logic [15:0]  core_io_opcode;
    logic [3:0]   core_reset_exec;
    logic [3:0]   core_enable_exec;
    logic [3:0]   core_done_exec = '0;
    logic [127:0] core_out = '0;

    int n_tests = 0;
    int n_fail  = 0;

    dpu_host_seq #(
        .N_CORES    (4),
        .DATA_W     (32),
        .OPC_W      (4),
        .FIFO_DEPTH (8),
        .TMO_W      (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_mask         (cmd_mask),
        .cmd_data         (cmd_data),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_core         (res_core),
        .status_err       (status_err),
        .core_in          (core_in),
        .core_io_opcode   (core_io_opcode),
        .core_reset_exec  (core_reset_exec),
        .core_enable_exec (core_enable_exec),
        .core_done_exec   (core_done_exec),
        .core_out         (core_out)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] cin(input int i);
        return core_in[i*32 +: 32];
    endfunction

    function automatic logic [3:0] copc(input int i);
        return core_io_opcode[i*4 +: 4];
    endfunction

    // Called on a negedge; the command is accepted at the next posedge and we return on the following negedge.
    task automatic push(input logic [2:0] op, input logic [3:0] m, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = m; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cmd_ready, res_valid, core_reset_exec, core_enable_exec, status_err} !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b rv=%b rst=%h en=%h err=%b, required 1 0 0 0 0",
                     cmd_ready, res_valid, core_reset_exec, core_enable_exec, status_err);
        end
        n_tests++;
        if (core_in !== '0 || core_io_opcode !== '0) begin
            n_fail++;
            $display("FAIL reset_core: got in=%h opc=%h, required 0 0", core_in, core_io_opcode);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load;
        push(OP_DATA, 4'b0101, 32'hDEADBEEF);
        @(negedge clk);
        n_tests++;
        if ({cin(0), cin(1), cin(2), cin(3)} !== {32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0}) begin
            n_fail++;
            $display("FAIL load_data_in: got %h %h %h %h, required DEADBEEF 0 DEADBEEF 0", cin(0), cin(1), cin(2), cin(3));
        end
        n_tests++;
        if (core_io_opcode !== {IO_NOP, IO_DATA, IO_NOP, IO_DATA}) begin
            n_fail++;
            $display("FAIL load_data_opc: got %h, required %h", core_io_opcode, {IO_NOP, IO_DATA, IO_NOP, IO_DATA});
        end
        @(negedge clk);
        n_tests++;
        if (core_in !== '0 || core_io_opcode !== '0) begin
            n_fail++;
            $display("FAIL load_one_cycle: got in=%h opc=%h, required 0 0", core_in, core_io_opcode);
        end
    endtask

    task automatic test_back_to_back;
        cmd_valid = 1'b1; cmd_op = OP_CFG; cmd_mask = 4'b0010; cmd_data = 32'h12345678;
        @(negedge clk);
        cmd_op = OP_PROG; cmd_mask = 4'b1000; cmd_data = 32'hCAFE0001;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_tests++;
        if (cin(1) !== 32'h12345678 || core_io_opcode !== 16'h0010) begin
            n_fail++;
            $display("FAIL b2b_cfg: got in1=%h opc=%h, required 12345678 0010", cin(1), core_io_opcode);
        end
        @(negedge clk);
        n_tests++;
        if (core_io_opcode !== 16'h0000) begin
            n_fail++;
            $display("FAIL b2b_gap: got opc=%h, required 0000", core_io_opcode);
        end
        @(negedge clk);
        n_tests++;
        if (cin(3) !== 32'hCAFE0001 || core_io_opcode !== 16'h3000) begin
            n_fail++;
            $display("FAIL b2b_prog: got in3=%h opc=%h, required CAFE0001 3000", cin(3), core_io_opcode);
        end
        // Zero-mask EXEC and plain NOP must leave the cores untouched.
        push(OP_EXEC, 4'b0000, 32'h0);
        push(OP_NOP, 4'b1111, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (core_reset_exec !== 4'h0 || core_enable_exec !== 4'h0 || core_io_opcode !== 16'h0) begin
                n_fail++;
                $display("FAIL mask0_quiet[%0d]: got rst=%h en=%h opc=%h, required 0 0 0",
                         k, core_reset_exec, core_enable_exec, core_io_opcode);
            end
            @(negedge clk);
        end
        // done already high when RUN starts: enable lasts exactly one cycle.
        core_done_exec = 4'b0001;
        push(OP_EXEC, 4'b0001, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (core_enable_exec !== 4'b0001) begin
            n_fail++;
            $display("FAIL done_at_entry_run: got en=%b, required 0001", core_enable_exec);
        end
        @(negedge clk);
        n_tests++;
        if (core_enable_exec !== 4'b0000) begin
            n_fail++;
            $display("FAIL done_at_entry_exit: got en=%b, required 0000", core_enable_exec);
        end
        core_done_exec = 4'b0000;
    endtask

    task automatic test_exec;
        push(OP_EXEC, 4'b1111, 32'h0);
        @(negedge clk);
        n_tests++;
        if (core_reset_exec !== 4'b1111 || core_enable_exec !== 4'b0000) begin
            n_fail++;
            $display("FAIL exec_start: got rst=%b en=%b, required 1111 0000", core_reset_exec, core_enable_exec);
        end
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1 || c == 9 || c == 14 || c == 15) begin
                n_tests++;
                if (core_enable_exec !== ((c == 15) ? 4'b0000 : 4'b1111) || core_reset_exec !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL exec_cycle%0d: got en=%b rst=%b, required %b 0000",
                             c, core_enable_exec, core_reset_exec, (c == 15) ? 4'b0000 : 4'b1111);
                end
            end
            // core0 pulses once; cores 1,2 hold from cycle 9; core3 joins at 14
            core_done_exec[0] = (c == 5);
            core_done_exec[1] = (c >= 9);
            core_done_exec[2] = (c >= 9);
            core_done_exec[3] = (c >= 14);
        end
        core_done_exec = 4'b0000;
        n_tests++;
        if (status_err !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_no_err: got %b, required 0", status_err);
        end
    endtask

    task automatic test_read;
        logic seen;
        core_out  = {32'hC3C3C3C3, 32'h22222222, 32'hA1A1A1A1, 32'h11111111};
        res_ready = 1'b0;
        seen      = 1'b0;
        push(OP_READ, 4'b1010, 32'h0);
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = res_valid;
        end
        n_tests++;
        if (!seen || res_core !== 2'd1 || res_data !== 32'hA1A1A1A1) begin
            n_fail++;
            $display("FAIL read_first: got v=%b core=%0d data=%h, required 1 1 A1A1A1A1", seen, res_core, res_data);
        end
        core_out[32 +: 32] = 32'hFFFF0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (res_valid !== 1'b1 || res_core !== 2'd1 || res_data !== 32'hA1A1A1A1) begin
                n_fail++;
                $display("FAIL read_stall[%0d]: got v=%b core=%0d data=%h, required 1 1 A1A1A1A1",
                         k, res_valid, res_core, res_data);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (res_valid !== 1'b1 || res_core !== 2'd3 || res_data !== 32'hC3C3C3C3) begin
            n_fail++;
            $display("FAIL read_second: got v=%b core=%0d data=%h, required 1 3 C3C3C3C3", res_valid, res_core, res_data);
        end
        @(negedge clk);
        n_tests++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: got v=%b, required 0", res_valid);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_fifo_full;
        int got;
        core_out[31:0] = 32'h77777777;
        res_ready = 1'b0;
        push(OP_READ, 4'b0001, 32'h0);
        @(negedge clk);
        n_tests++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_busy: got v=%b, required 1", res_valid);
        end
        for (int i = 1; i <= 9; i++) begin
            n_tests++;
            if (cmd_ready !== (i <= 8)) begin
                n_fail++;
                $display("FAIL full_ready[%0d]: got %b, required %b", i, cmd_ready, (i <= 8));
            end
            cmd_valid = 1'b1; cmd_op = OP_DATA; cmd_mask = 4'b0001; cmd_data = 32'(i);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            if (copc(0) === IO_DATA) begin
                got++;
                n_tests++;
                if (cin(0) !== 32'(got)) begin
                    n_fail++;
                    $display("FAIL full_order[%0d]: got %h, required %h", got, cin(0), 32'(got));
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (got != 8 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_count: got loads=%0d rdy=%b, required 8 1", got, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        push(OP_EXEC, 4'b1111, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (core_enable_exec !== 4'b1111) begin
            n_fail++;
            $display("FAIL midrun_enter: got en=%b, required 1111", core_enable_exec);
        end
        push(OP_CFG, 4'b0001, 32'h5A5A5A5A);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({cmd_ready, res_valid, core_reset_exec, core_enable_exec} !== {1'b1, 1'b0, 4'h0, 4'h0} ||
                core_in !== '0 || core_io_opcode !== '0) begin
                n_fail++;
                $display("FAIL midrun_reset[%0d]: got rdy=%b v=%b rst=%h en=%h opc=%h, required 1 0 0 0 0",
                         k, cmd_ready, res_valid, core_reset_exec, core_enable_exec, core_io_opcode);
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (core_enable_exec !== 4'h0 || core_io_opcode !== '0) begin
                n_fail++;
                $display("FAIL midrun_idle[%0d]: got en=%h opc=%h, required 0 0", k, core_enable_exec, core_io_opcode);
            end
        end
    endtask

`ifdef DPU_HOST_TIMEOUT_EN
    task automatic test_timeout;
        push(OP_EXEC, 4'b0100, 32'h0);
        @(negedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1 || c == 15 || c == 16) begin
                n_tests++;
                if (core_enable_exec !== ((c == 16) ? 4'b0000 : 4'b0100) || status_err !== (c == 16)) begin
                    n_fail++;
                    $display("FAIL timeout_c%0d: got en=%b err=%b, required %b %b",
                             c, core_enable_exec, status_err, (c == 16) ? 4'b0000 : 4'b0100, (c == 16));
                end
            end
        end
        push(OP_CFG, 4'b0001, 32'h99);
        n_tests++;
        if (copc(0) !== IO_CFG || cin(0) !== 32'h99 || status_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_next: got opc0=%h in0=%h err=%b, required 1 99 1", copc(0), cin(0), status_err);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset;
        test_load;
        test_back_to_back;
        test_exec;
        test_read;
        test_fifo_full;
        test_reset_mid_run;
`ifdef DPU_HOST_TIMEOUT_EN
        test_timeout;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
